snake_dir_step_ctrl: RTL

//  Upstream stage of the snake length/position engine. Turns debounced single-cycle

---
 rtl/snake_dir_step_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/snake_dir_step_ctrl.sv
// snake_dir_step_ctrl: queues reversal-filtered button directions and paces the snake's step pulse by length
module snake_dir_step_ctrl #(
  parameter logic [1:0] INIT_DIRN   = 2'b11,
  parameter int         DEPTH       = 2,
  parameter int         CNT_W       = 32,
  parameter int         BASE_PERIOD = 25_000_000,
  parameter int         STEP_DEC    = 500_000,
  parameter int         MIN_PERIOD  = 5_000_000,
  parameter int         INIT_LEN    = 3
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       BtnU_SCEN,
  input  logic       BtnD_SCEN,
  input  logic       BtnL_SCEN,
  input  logic       BtnR_SCEN,
  input  logic       q_I,
  input  logic       q_Run,
  input  logic [7:0] Length,
  output logic       Move_Tick,
  output logic [1:0] Cur_Dirn,
  output logic [2:0] Queue_Count,
  output logic       Drop
);
  localparam int PW = CNT_W + 9;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, p_next;
  logic             move_tick_q, move_tick_d, drop_q, drop_d;
  logic [1:0]       cur_dirn_q, cur_dirn_d;
  logic [2:0]       queue_count_q, queue_count_d, wr_idx;
  logic [1:0]       fifo_q [DEPTH];
  logic [1:0]       fifo_d [DEPTH];
  logic             press_v, wrap, pop, accept, push;
  logic [1:0]       press_dir, tail;
  logic [7:0]       len_over;
  logic signed [PW-1:0] p_raw;
  assign press_v   = BtnU_SCEN | BtnD_SCEN | BtnL_SCEN | BtnR_SCEN;
  assign press_dir = BtnU_SCEN ? 2'b00 : BtnD_SCEN ? 2'b01 : BtnL_SCEN ? 2'b10 : 2'b11;
  assign len_over  = Length - 8'(INIT_LEN);
  assign p_raw     = $signed(PW'(BASE_PERIOD)) - $signed(PW'(len_over)) * $signed(PW'(STEP_DEC));
  assign p_next    = (Length <= 8'(INIT_LEN)) ? CNT_W'(BASE_PERIOD) :
                     (p_raw < $signed(PW'(MIN_PERIOD))) ? CNT_W'(MIN_PERIOD) : CNT_W'(p_raw);
  assign wrap      = q_Run && (cnt_q == period_q - CNT_W'(1));
  assign pop       = wrap && (queue_count_q != 3'd0);
  assign accept    = q_Run && press_v && (press_dir != tail) && (press_dir != (tail ^ 2'b01));
  assign push      = accept && ((queue_count_q < 3'(DEPTH)) || pop);
  assign wr_idx    = queue_count_q - {2'b00, pop};
  // Reference direction for the reversal filter: newest queued entry, else the applied direction
  always_comb begin
    tail = cur_dirn_q;
    for (int i = 0; i < DEPTH; i++) if (queue_count_q == 3'(i + 1)) tail = fifo_q[i];
  end
  // Queue update: shift toward the head on pop, then write the new press behind the survivors
  always_comb begin
    fifo_d = fifo_q;
    if (pop) for (int i = 0; i < DEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
    for (int i = 0; i < DEPTH; i++) if (push && wr_idx == 3'(i)) fifo_d[i] = press_dir;
  end
  // Step timing, queue occupancy and applied direction; period is only re-sampled at each tick
  always_comb begin
    cnt_d         = (!q_Run || wrap) ? '0 : cnt_q + CNT_W'(1);
    period_d      = !q_Run ? CNT_W'(BASE_PERIOD) : wrap ? p_next : period_q;
    move_tick_d   = wrap;
    drop_d        = accept && !push;
    queue_count_d = !q_Run ? 3'd0 : queue_count_q + {2'b00, push} - {2'b00, pop};
    cur_dirn_d    = q_I ? INIT_DIRN : pop ? fifo_q[0] : cur_dirn_q;
  end
  // State registers, cleared immediately by the asynchronous reset
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cnt_q         <= '0;
      period_q      <= CNT_W'(BASE_PERIOD);
      move_tick_q   <= 1'b0;
      drop_q        <= 1'b0;
      cur_dirn_q    <= INIT_DIRN;
      queue_count_q <= 3'd0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= INIT_DIRN;
    end else begin
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      move_tick_q   <= move_tick_d;
      drop_q        <= drop_d;
      cur_dirn_q    <= cur_dirn_d;
      queue_count_q <= queue_count_d;
      fifo_q        <= fifo_d;
    end
  end
  assign Move_Tick   = move_tick_q;
  assign Cur_Dirn    = cur_dirn_q;
  assign Queue_Count = queue_count_q;
  assign Drop        = drop_q;
endmodule
